// File: rtl/merlin_dport_sram_pkg.sv
// -----------------------------------------------------------------------------
// merlin_dport_sram_pkg
// Shared types and helpers for the Merlin data-port SRAM.
// The XLEN and access-size encodings mirror the core's riscv_defs values so
// that this block decodes requests exactly like the rest of the pipeline.
// -----------------------------------------------------------------------------
package merlin_dport_sram_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [1:0] RV_MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] RV_MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] RV_MEM_SIZE_WORD = 2'b10;

    localparam logic [1:0] HPL_USER = 2'b00;

    // One buffered response: fault flags plus load data or faulting address.
    typedef struct packed {
        logic               rerr;
        logic               werr;
        logic [RV_XLEN-1:0] data;
    } rsp_t;

    // Byte-lane write strobes for a store of the given size and offset.
    function automatic logic [3:0] byte_strobe(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] strobe;
        case (size)
            RV_MEM_SIZE_BYTE: strobe = 4'b0001 << addr_lo;
            RV_MEM_SIZE_HALF: strobe = 4'b0011 << addr_lo;
            RV_MEM_SIZE_WORD: strobe = 4'b1111;
            default:          strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

    // Size/alignment fault; the illegal size encoding always faults.
    function automatic logic align_fault(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
        logic fault;
        case (size)
            RV_MEM_SIZE_BYTE: fault = 1'b0;
            RV_MEM_SIZE_HALF: fault = addr_lo[0];
            RV_MEM_SIZE_WORD: fault = (addr_lo != 2'b00);
            default:          fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/merlin_fifo.sv
// -----------------------------------------------------------------------------
// merlin_fifo
// Synchronous valid/ready FIFO of 2^C_FIFO_DEPTH_X entries. With
// C_FIFO_PASSTHROUGH=1 an empty FIFO forwards its input combinationally.
// Ports: clk_i, reset_i (sync, active-high), flush_i (sync clear),
//        valid_i/ready_o/data_i (write side), valid_o/ready_i/data_o (read).
// data_o reads as zero while nothing is presented.
// -----------------------------------------------------------------------------
module merlin_fifo #(
    parameter int C_FIFO_PASSTHROUGH = 0,
    parameter int C_FIFO_WIDTH       = 34,
    parameter int C_FIFO_DEPTH_X     = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [C_FIFO_WIDTH-1:0] data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [C_FIFO_WIDTH-1:0] data_o
);
    localparam int DEPTH = 1 << C_FIFO_DEPTH_X;
    localparam int PW    = C_FIFO_DEPTH_X + 1;

    logic [C_FIFO_WIDTH-1:0] store_r [DEPTH];
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic                    empty_s;
    logic                    full_s;
    logic                    bypass_s;
    logic                    push_s;
    logic                    pop_s;

    // Occupancy flags, optional empty bypass, and push/pop qualification
    always_comb begin
        empty_s  = (wr_ptr_r == rd_ptr_r);
        full_s   = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                   (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
        bypass_s = (C_FIFO_PASSTHROUGH != 32'sd0) && empty_s && valid_i;
        ready_o  = ~full_s;
        valid_o  = ~empty_s | bypass_s;
        if (!empty_s) begin
            data_o = store_r[rd_ptr_r[PW-2:0]];
        end else if (bypass_s) begin
            data_o = data_i;
        end else begin
            data_o = {C_FIFO_WIDTH{1'b0}};
        end
        // A bypassed word consumed in the same cycle is never stored.
        push_s = valid_i & ~full_s & ~(bypass_s & ready_i);
        pop_s  = ~empty_s & ready_i;
    end

    // Read/write pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{C_FIFO_DEPTH_X{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{C_FIFO_DEPTH_X{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; contents are don't-care until a pointer covers them
    always_ff @(posedge clk_i) begin
        if (push_s && !reset_i && !flush_i) begin
            store_r[wr_ptr_r[PW-2:0]] <= data_i;
        end
    end

endmodule

// File: rtl/merlin_dport_sram.sv
// -----------------------------------------------------------------------------
// merlin_dport_sram
// Tightly coupled data SRAM for the Merlin core's data port.
// Ports:
//   clk_i, reset_i (sync, active-high), clk_en_i (global clock enable)
//   dreq*  : request channel (valid/ready, size, write, hpl, addr, data)
//   drsp*  : response channel (valid/ready, rerr, werr, data)
// Loads and faulting stores each return one in-order response; good stores
// are silent. Memory is read synchronously into a one-deep stage, which
// feeds a response FIFO. An outstanding-response counter ensures the FIFO
// can never overflow.
// -----------------------------------------------------------------------------
module merlin_dport_sram
    import merlin_dport_sram_pkg::*;
#(
    parameter int          C_MEM_DEPTH_X      = 10,
    parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
    parameter int          C_RSP_FIFO_DEPTH_X = 1,
    parameter int          C_USER_ACCESS      = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clk_en_i,
    output logic               dreqready_o,
    input  logic               dreqvalid_i,
    input  logic [1:0]         dreqsize_i,
    input  logic               dreqwrite_i,
    input  logic [1:0]         dreqhpl_i,
    input  logic [RV_XLEN-1:0] dreqaddr_i,
    input  logic [RV_XLEN-1:0] dreqdata_i,
    input  logic               drspready_i,
    output logic               drspvalid_o,
    output logic               drsprerr_o,
    output logic               drspwerr_o,
    output logic [RV_XLEN-1:0] drspdata_o
);
    localparam int MEM_WORDS = 1 << C_MEM_DEPTH_X;
    localparam int AW        = C_MEM_DEPTH_X + 2;
    localparam int CW        = C_RSP_FIFO_DEPTH_X + 1;

    logic [RV_XLEN-1:0]       mem_r [MEM_WORDS];
    logic [C_MEM_DEPTH_X-1:0] word_idx_s;
    logic [3:0]               strobe_s;
    logic                     fault_s;
    logic                     store_ok_s;
    logic                     req_hs_s;
    logic                     need_rsp_s;
    logic                     wr_en_s;
    logic                     rsp_hs_s;
    logic [CW-1:0]            outstanding_r;
    logic                     s1_valid_r;
    logic                     s1_rerr_r;
    logic                     s1_werr_r;
    logic [RV_XLEN-1:0]       s1_addr_r;
    logic [RV_XLEN-1:0]       s1_rdata_r;
    rsp_t                     push_data_s;
    rsp_t                     head_s;
    logic                     fifo_ready_s;
    logic                     fifo_valid_s;
    logic                     fifo_push_s;

    // Request decode, credit check and handshake qualification
    always_comb begin
        // The base is size-aligned, so range check is an upper-bit compare.
        fault_s = align_fault(dreqsize_i, dreqaddr_i[1:0])
                | (dreqaddr_i[RV_XLEN-1:AW] != C_BASE_ADDR[RV_XLEN-1:AW])
                | ((C_USER_ACCESS == 32'sd0) && (dreqhpl_i == HPL_USER));
        strobe_s   = byte_strobe(dreqsize_i, dreqaddr_i[1:0]);
        word_idx_s = dreqaddr_i[AW-1:2];
        store_ok_s = dreqwrite_i & ~fault_s;
        // Counter is one bit wider than log2(depth): its MSB set means no
        // credit left. Good stores need no credit, so they bypass the limit.
        dreqready_o = clk_en_i & (~outstanding_r[CW-1] | store_ok_s);
        req_hs_s    = dreqvalid_i & dreqready_o;
        need_rsp_s  = req_hs_s & (~dreqwrite_i | fault_s);
        wr_en_s     = req_hs_s & store_ok_s & ~reset_i;
        rsp_hs_s    = clk_en_i & drspvalid_o & drspready_i;
    end

    // Byte-masked store into the single-port array (contents survive reset)
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (strobe_s[lane]) begin
                    mem_r[word_idx_s][8*lane +: 8] <= dreqdata_i[8*lane +: 8];
                end
            end
        end
    end

    // Read stage: registers the response-producing request and its read data
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_r <= 1'b0;
            s1_rerr_r  <= 1'b0;
            s1_werr_r  <= 1'b0;
            s1_addr_r  <= {RV_XLEN{1'b0}};
            s1_rdata_r <= {RV_XLEN{1'b0}};
        end else if (clk_en_i) begin
            s1_valid_r <= need_rsp_s;
            if (need_rsp_s) begin
                s1_rerr_r <= fault_s & ~dreqwrite_i;
                s1_werr_r <= fault_s & dreqwrite_i;
                s1_addr_r <= dreqaddr_i;
            end
            // Faulting loads leave the array untouched.
            if (need_rsp_s && !fault_s) begin
                s1_rdata_r <= mem_r[word_idx_s];
            end
        end
    end

    // Outstanding responses: accepted-but-not-yet-popped, stage plus FIFO
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            outstanding_r <= {CW{1'b0}};
        end else if (clk_en_i) begin
            case ({need_rsp_s, rsp_hs_s})
                2'b10:   outstanding_r <= outstanding_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   outstanding_r <= outstanding_r - {{(CW-1){1'b0}}, 1'b1};
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Stage-to-FIFO response formatting
    always_comb begin
        push_data_s.rerr = s1_rerr_r;
        push_data_s.werr = s1_werr_r;
        if (s1_rerr_r || s1_werr_r) begin
            push_data_s.data = s1_addr_r;
        end else begin
            push_data_s.data = s1_rdata_r;
        end
        fifo_push_s = s1_valid_r & clk_en_i & fifo_ready_s;
    end

    merlin_fifo #(
        .C_FIFO_PASSTHROUGH (0),
        .C_FIFO_WIDTH       ($bits(rsp_t)),
        .C_FIFO_DEPTH_X     (C_RSP_FIFO_DEPTH_X)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (1'b0),
        .valid_i (fifo_push_s),
        .ready_o (fifo_ready_s),
        .data_i  (push_data_s),
        .valid_o (fifo_valid_s),
        .ready_i (clk_en_i & drspready_i),
        .data_o  (head_s)
    );

    assign drspvalid_o = fifo_valid_s;
    assign drsprerr_o  = head_s.rerr;
    assign drspwerr_o  = head_s.werr;
    assign drspdata_o  = head_s.data;

endmodule

// File: tb/tb_merlin_dport_sram.sv
// -----------------------------------------------------------------------------
// tb_merlin_dport_sram
// Directed stimulus with a response scoreboard: expected responses are queued
// when a request is accepted and popped by an independent monitor whenever a
// response handshake is about to occur.
// -----------------------------------------------------------------------------
module tb_merlin_dport_sram;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic        dreqready_o;
    logic        dreqvalid_i;
    logic [1:0]  dreqsize_i;
    logic        dreqwrite_i;
    logic [1:0]  dreqhpl_i;
    logic [31:0] dreqaddr_i;
    logic [31:0] dreqdata_i;
    logic        drspready_i;
    logic        drspvalid_o;
    logic        drsprerr_o;
    logic        drspwerr_o;
    logic [31:0] drspdata_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          raise_cyc;
    logic [33:0] sb [$];
    logic [33:0] exp_v;

    merlin_dport_sram #(
        .C_MEM_DEPTH_X      (10),
        .C_BASE_ADDR        (32'h0000_0000),
        .C_RSP_FIFO_DEPTH_X (1),
        .C_USER_ACCESS      (1)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clk_en_i    (clk_en_i),
        .dreqready_o (dreqready_o),
        .dreqvalid_i (dreqvalid_i),
        .dreqsize_i  (dreqsize_i),
        .dreqwrite_i (dreqwrite_i),
        .dreqhpl_i   (dreqhpl_i),
        .dreqaddr_i  (dreqaddr_i),
        .dreqdata_i  (dreqdata_i),
        .drspready_i (drspready_i),
        .drspvalid_o (drspvalid_o),
        .drsprerr_o  (drsprerr_o),
        .drspwerr_o  (drspwerr_o),
        .drspdata_o  (drspdata_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake happens at the next rising edge; compare now.
    always @(negedge clk_i) begin
        if (!reset_i && clk_en_i && drspvalid_o && drspready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got %h expected none",
                         {drsprerr_o, drspwerr_o, drspdata_o});
            end else begin
                exp_v = sb.pop_front();
                check("rsp", {drsprerr_o, drspwerr_o, drspdata_o}, exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request; waits (bounded) for acceptance, queues the response.
    task automatic req(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] data, input logic has_rsp, input logic [33:0] rsp);
        dreqvalid_i = 1'b1;
        dreqwrite_i = wr;
        dreqsize_i  = sz;
        dreqaddr_i  = addr;
        dreqdata_i  = data;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (dreqready_o) begin
                tick();
                if (has_rsp) sb.push_back(rsp);
                dreqvalid_i = 1'b0;
                acc_cyc = cyc;
                return;
            end
        end
        n_checks++;
        $display("FAIL req_timeout: got no accept expected accept for addr %h", addr);
        dreqvalid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check("drain", 34'(sb.size()), 34'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; clk_en_i = 1'b1; dreqvalid_i = 1'b0; dreqsize_i = SZ_W;
        dreqwrite_i = 1'b0; dreqhpl_i = 2'b11; dreqaddr_i = 32'h0; dreqdata_i = 32'h0;
        drspready_i = 1'b1;
        tick(); tick(); tick();
        reset_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        check("rst_valid", 34'(drspvalid_o), 34'd0);
        check("rst_rerr",  34'(drsprerr_o),  34'd0);
        check("rst_werr",  34'(drspwerr_o),  34'd0);
        check("rst_data",  34'(drspdata_o),  34'd0);
        check("rst_ready", 34'(dreqready_o), 34'd1);
        tick();

        // Preload, then byte store into the top lane of word 0
        req(1'b1, SZ_W, 32'h0000_0000, 32'h1122_3344, 1'b0, 34'd0);
        req(1'b1, SZ_W, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 34'd0);
        req(1'b1, SZ_W, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b0, 34'd0);
        req(1'b1, SZ_B, 32'h0000_0003, 32'hA5A5_A5A5, 1'b0, 34'd0);
        dreqhpl_i = 2'b00;
        req(1'b0, SZ_W, 32'h0000_0000, 32'h0, 1'b1, {2'b00, 32'hA522_3344});
        dreqhpl_i = 2'b11;
        drain();

        // Misaligned half load: fault, response visible one edge after accept
        req(1'b0, SZ_H, 32'h0000_0001, 32'h0, 1'b1, {2'b10, 32'h0000_0001});
        @(negedge clk_i);
        check("lat_early", 34'(drspvalid_o), 34'd0);
        @(negedge clk_i);
        check("lat_due", 34'(drspvalid_o), 34'd1);
        tick();
        drain();

        // Out-of-range store faults and leaves memory alone
        req(1'b1, SZ_W, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, {2'b01, 32'h0000_1000});
        req(1'b0, SZ_W, 32'h0000_0000, 32'h0, 1'b1, {2'b00, 32'hA522_3344});
        // Half then byte stores, load immediately afterwards
        req(1'b1, SZ_H, 32'h0000_0006, 32'hCAFE_CAFE, 1'b0, 34'd0);
        req(1'b1, SZ_B, 32'h0000_0005, 32'h5A5A_5A5A, 1'b0, 34'd0);
        req(1'b0, SZ_W, 32'h0000_0004, 32'h0, 1'b1, {2'b00, 32'hCAFE_5AEF});
        // Fault classes and an unshifted sub-word load
        req(1'b0, SZ_X, 32'h0000_0008, 32'h0, 1'b1, {2'b10, 32'h0000_0008});
        req(1'b0, SZ_W, 32'h0000_0002, 32'h0, 1'b1, {2'b10, 32'h0000_0002});
        req(1'b0, SZ_W, 32'h0000_1000, 32'h0, 1'b1, {2'b10, 32'h0000_1000});
        req(1'b1, SZ_H, 32'h0000_0003, 32'h1234_1234, 1'b1, {2'b01, 32'h0000_0003});
        req(1'b1, SZ_B, 32'hFFFF_FFFF, 32'h0, 1'b1, {2'b01, 32'hFFFF_FFFF});
        req(1'b0, SZ_B, 32'h0000_0FFF, 32'h0, 1'b1, {2'b00, 32'h0BAD_F00D});
        req(1'b0, SZ_W, 32'h0000_0000, 32'h0, 1'b1, {2'b00, 32'hA522_3344});
        drain();

        // Credit limit: two loads fill the buffer; a good store still goes in
        drspready_i = 1'b0;
        req(1'b0, SZ_W, 32'h0000_0000, 32'h0, 1'b1, {2'b00, 32'hA522_3344});
        req(1'b0, SZ_W, 32'h0000_0004, 32'h0, 1'b1, {2'b00, 32'hCAFE_5AEF});
        req(1'b1, SZ_W, 32'h0000_0008, 32'h1234_5678, 1'b0, 34'd0);
        dreqvalid_i = 1'b1; dreqwrite_i = 1'b0; dreqsize_i = SZ_W; dreqaddr_i = 32'h0000_0FFC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("credit_ready", 34'(dreqready_o), 34'd0);
            tick();
        end
        drspready_i = 1'b1;
        raise_cyc = cyc;
        req(1'b0, SZ_W, 32'h0000_0FFC, 32'h0, 1'b1, {2'b00, 32'h0BAD_F00D});
        check("third_accept_cyc", 34'(acc_cyc), 34'(raise_cyc + 2));
        drain();

        // Clock-enable freeze with two responses buffered
        drspready_i = 1'b0;
        req(1'b0, SZ_W, 32'h0000_0008, 32'h0, 1'b1, {2'b00, 32'h1234_5678});
        req(1'b0, SZ_W, 32'h0000_0004, 32'h0, 1'b1, {2'b00, 32'hCAFE_5AEF});
        tick();
        clk_en_i = 1'b0;
        drspready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("frz_valid", 34'(drspvalid_o), 34'd1);
            check("frz_head", {drsprerr_o, drspwerr_o, drspdata_o}, {2'b00, 32'h1234_5678});
            check("frz_ready", 34'(dreqready_o), 34'd0);
            tick();
        end
        clk_en_i = 1'b1;
        drain();

        // Reset (with clock enable low) while two responses are buffered
        drspready_i = 1'b0;
        req(1'b0, SZ_W, 32'h0000_0000, 32'h0, 1'b1, {2'b00, 32'hA522_3344});
        req(1'b0, SZ_W, 32'h0000_0004, 32'h0, 1'b1, {2'b00, 32'hCAFE_5AEF});
        tick();
        clk_en_i = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        clk_en_i = 1'b1;
        sb.delete();
        drspready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("post_rst_valid", 34'(drspvalid_o), 34'd0);
            check("post_rst_ready", 34'(dreqready_o), 34'd1);
            tick();
        end
        // Counter must be back to zero: two loads fit with no pops
        drspready_i = 1'b0;
        req(1'b0, SZ_W, 32'h0000_0000, 32'h0, 1'b1, {2'b00, 32'hA522_3344});
        @(negedge clk_i);
        check("post_rst_credit", 34'(dreqready_o), 34'd1);
        tick();
        drspready_i = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
